jtag_tap_bscan: RTL and testbench

- Parametrised IEEE 1149.1-style TAP controller with an integrated boundary-scan register (BSR) wrapping a generic core of N_IN inputs and N_OUT outputs.
- Generalises the fixed 14-cell adder wrapper to arbitrary chain length and IR width.
- Adds a decoded instruction set, a mode-dependent pin/core mux, an optional 32-bit IDCODE register, and an explicit update latch.
- Sits between device pins and the core logic. It is the single scan access point for board-level and internal test.

---
 rtl/jtag_tap_bscan_if.sv | 11 +
 rtl/jtag_tap_bscan.sv | 177 +++++++++++++++++
 tb/tb_jtag_tap_bscan.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_bscan_if.sv
// Serial JTAG signals of the TAP: mode select, data in, data out and its enable.
// The tester drives the master side and the TAP is the slave.
interface jtag_tap_bscan_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic enableTDO;

    modport master (output TMS, output TDI, input TDO, input enableTDO);
    modport slave  (input TMS, input TDI, output TDO, output enableTDO);
endinterface

// File: rtl/jtag_tap_bscan.sv
// IEEE 1149.1-style TAP controller with a boundary-scan register around an N_IN/N_OUT core.
// Define JTAG_IDCODE_EN to build the 32-bit IDCODE register; otherwise the IDCODE opcode acts as BYPASS.
module jtag_tap_bscan #(
    parameter int          N_IN       = 9,
    parameter int          N_OUT      = 5,
    parameter int          IR_SIZE    = 3,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic               TCK,
    input  logic               TRST,
    jtag_tap_bscan_if.slave    jtag,
    input  logic [N_IN-1:0]    pin_in,
    output logic [N_IN-1:0]    core_in,
    input  logic [N_OUT-1:0]   core_out,
    output logic [N_OUT-1:0]   pin_out,
    output logic [IR_SIZE-1:0] ir_value
);
    localparam int N_BSR = N_IN + N_OUT;

    localparam logic [IR_SIZE-1:0] OP_EXTEST = IR_SIZE'(0);
    localparam logic [IR_SIZE-1:0] OP_SAMPLE = IR_SIZE'(2);
    localparam logic [IR_SIZE-1:0] OP_INTEST = IR_SIZE'(3);
    localparam logic [IR_SIZE-1:0] OP_IDCODE = IR_SIZE'(5);

    if (IR_SIZE < 3) begin : g_bad_ir_size
        $error("IR_SIZE must be at least 3");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VAL bit 0 must be 1");
    end

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e         state_q, state_d;
    logic [IR_SIZE-1:0] ir_q, ir_d;
    logic [IR_SIZE-1:0] sh_ir_q, sh_ir_d;
    logic [N_BSR-1:0]   bsr_q, bsr_d;
    logic [N_BSR-1:0]   latch_q, latch_d;
    logic               byp_q, byp_d;
`ifdef JTAG_IDCODE_EN
    logic [31:0]        idc_q, idc_d;
    logic               sel_idc;
`endif
    logic               sel_bsr;
    logic               dr_bit;
    logic               tdo_q, tdo_d;
    logic               en_q, en_d;

    assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE) || (ir_q == OP_INTEST);
`ifdef JTAG_IDCODE_EN
    assign sel_idc = (ir_q == OP_IDCODE);
    assign dr_bit  = sel_bsr ? bsr_q[0] : (sel_idc ? idc_q[0] : byp_q);
`else
    assign dr_bit  = sel_bsr ? bsr_q[0] : byp_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = jtag.TMS ? TLR    : RTI;
            RTI:     state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = jtag.TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = jtag.TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = jtag.TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = jtag.TMS ? UPD_DR : PA_DR;
            PA_DR:   state_d = jtag.TMS ? EX2_DR : PA_DR;
            EX2_DR:  state_d = jtag.TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = jtag.TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = jtag.TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = jtag.TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = jtag.TMS ? UPD_IR : PA_IR;
            PA_IR:   state_d = jtag.TMS ? EX2_IR : PA_IR;
            EX2_IR:  state_d = jtag.TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = jtag.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Only the register selected by the current IR captures, shifts or updates.
    always_comb begin
        ir_d    = ir_q;
        sh_ir_d = sh_ir_q;
        bsr_d   = bsr_q;
        latch_d = latch_q;
        byp_d   = byp_q;
`ifdef JTAG_IDCODE_EN
        idc_d   = idc_q;
`endif
        case (state_q)
            CAP_IR: sh_ir_d = IR_SIZE'(2'b01);
            SH_IR:  sh_ir_d = {jtag.TDI, sh_ir_q[IR_SIZE-1:1]};
            UPD_IR: ir_d    = sh_ir_q;
            CAP_DR: begin
                if (sel_bsr) bsr_d = {core_out, pin_in};
`ifdef JTAG_IDCODE_EN
                else if (sel_idc) idc_d = IDCODE_VAL;
`endif
                else byp_d = 1'b0;
            end
            SH_DR: begin
                if (sel_bsr) bsr_d = {jtag.TDI, bsr_q[N_BSR-1:1]};
`ifdef JTAG_IDCODE_EN
                else if (sel_idc) idc_d = {jtag.TDI, idc_q[31:1]};
`endif
                else byp_d = jtag.TDI;
            end
            UPD_DR: if (sel_bsr) latch_d = bsr_q;
            default: ;
        endcase
        if (state_d == TLR) begin
            ir_d    = '1;
            latch_d = '0;
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= TLR;
            ir_q    <= '1;
            sh_ir_q <= '0;
            bsr_q   <= '0;
            latch_q <= '0;
            byp_q   <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            sh_ir_q <= sh_ir_d;
            bsr_q   <= bsr_d;
            latch_q <= latch_d;
            byp_q   <= byp_d;
`ifdef JTAG_IDCODE_EN
            idc_q   <= idc_d;
`endif
        end
    end

    // TDO changes on the falling edge so the tester can sample it on the next rising edge.
    always_comb begin
        tdo_d = 1'b0;
        en_d  = 1'b0;
        if (state_q == SH_DR) begin
            tdo_d = dr_bit;
            en_d  = 1'b1;
        end else if (state_q == SH_IR) begin
            tdo_d = sh_ir_q[0];
            en_d  = 1'b1;
        end
    end

    always_ff @(negedge TCK) begin
        tdo_q <= tdo_d;
        en_q  <= en_d;
    end

    always_comb begin
        core_in = pin_in;
        pin_out = core_out;
        if (ir_q == OP_EXTEST) begin
            pin_out = latch_q[N_BSR-1:N_IN];
        end else if (ir_q == OP_INTEST) begin
            core_in = latch_q[N_IN-1:0];
            pin_out = latch_q[N_BSR-1:N_IN];
        end
    end

    assign jtag.TDO       = tdo_q;
    assign jtag.enableTDO = en_q;
    assign ir_value       = ir_q;
endmodule

// File: tb/tb_jtag_tap_bscan.sv
// Directed bench for jtag_tap_bscan: reset, bypass echo, IR capture/pause/update, BSR scans,
// a table of pin/core mux vectors per instruction, IDCODE readout and TAP reset paths.
module tb_jtag_tap_bscan;
    localparam logic [31:0] IDV = 32'h1000_0001;

    logic       TCK = 1'b0;
    logic       TRST;
    logic [8:0] pin_v, core_in;
    logic [4:0] core_out_v, pin_out;
    logic [2:0] ir_value;
    int         n_cmp = 0;
    int         n_err = 0;

    jtag_tap_bscan_if jt ();

    jtag_tap_bscan #(.N_IN(9), .N_OUT(5), .IR_SIZE(3), .IDCODE_VAL(IDV)) dut (
        .TCK(TCK), .TRST(TRST), .jtag(jt),
        .pin_in(pin_v), .core_in(core_in),
        .core_out(core_out_v), .pin_out(pin_out),
        .ir_value(ir_value)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic [2:0] op;
        logic [8:0] pin;
        logic [4:0] cout;
        logic [8:0] exp_ci;
        logic [4:0] exp_po;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        jt.TMS = tms;
        jt.TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // From the first Shift state: sample TDO before each shift, leave via Exit1 on the last bit.
    task automatic shift_bits(input logic [63:0] din, input int len, output logic [63:0] dout);
        dout    = '0;
        dout[0] = jt.TDO;
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, din[i]);
            if (i < len - 1) dout[i+1] = jt.TDO;
        end
    endtask

    task automatic to_update(input int pause);
        if (pause > 0) begin
            for (int i = 0; i < pause; i++) tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
        tick(1'b1, 1'b0);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int len, input int pause, output logic [63:0] dout);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        shift_bits(din, len, dout);
        to_update(pause);
        tick(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [2:0] op, input int pause);
        logic [63:0] d;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        shift_bits({61'b0, op}, 3, d);
        to_update(pause);
        tick(1'b0, 1'b0);
    endtask

    // Confirms the TAP sits in Test_Logic_Reset with BYPASS selected: walk to Shift_DR, echo a 1.
    task automatic check_bypass_from_tlr(input string tag);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check({tag, "_lead"}, {63'b0, jt.TDO}, 64'd0);
        check({tag, "_en"}, {63'b0, jt.enableTDO}, 64'd1);
        tick(1'b0, 1'b1);
        check({tag, "_echo"}, {63'b0, jt.TDO}, 64'd1);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    function automatic logic [4:0] core_model(input logic [8:0] ci);
        return {1'b0, ci[3:0]} + {1'b0, ci[7:4]} + {4'b0, ci[8]};
    endfunction

    initial begin
        logic [63:0] d;
        logic [13:0] pat1, pat2;
        logic [63:0] din;
        logic [9:0]  stream;
        logic [2:0]  cur_op;

        vecs[0]  = '{3'd0, 9'h1FF, 5'h00, 9'h1FF, 5'b10110};
        vecs[1]  = '{3'd0, 9'h000, 5'h1F, 9'h000, 5'b10110};
        vecs[2]  = '{3'd0, 9'h123, 5'h0A, 9'h123, 5'b10110};
        vecs[3]  = '{3'd3, 9'h155, 5'h15, 9'h0A5, 5'b10110};
        vecs[4]  = '{3'd3, 9'h0AA, 5'h0A, 9'h0A5, 5'b10110};
        vecs[5]  = '{3'd2, 9'h0C3, 5'h11, 9'h0C3, 5'h11};
        vecs[6]  = '{3'd4, 9'h03C, 5'h0E, 9'h03C, 5'h0E};
        vecs[7]  = '{3'd5, 9'h1E1, 5'h07, 9'h1E1, 5'h07};
        vecs[8]  = '{3'd6, 9'h0F0, 5'h19, 9'h0F0, 5'h19};
        vecs[9]  = '{3'd1, 9'h10F, 5'h03, 9'h10F, 5'h03};
        vecs[10] = '{3'd7, 9'h111, 5'h1C, 9'h111, 5'h1C};
        vecs[11] = '{3'd0, 9'h0AB, 5'h05, 9'h0AB, 5'b10110};

        TRST = 1'b1; jt.TMS = 1'b0; jt.TDI = 1'b0;
        pin_v = 9'h0F0; core_out_v = 5'h00;

        // reset and bypass echo
        tick(1'b0, 1'b0);
        TRST = 1'b0;
        check("rst_tdo", {63'b0, jt.TDO}, 64'd0);
        check("rst_en", {63'b0, jt.enableTDO}, 64'd0);
        check("rst_ir", {61'b0, ir_value}, 64'd7);
        check("rst_pin_out", {59'b0, pin_out}, {59'b0, core_out_v});
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("byp_lead", {63'b0, jt.TDO}, 64'd0);
        check("byp_en", {63'b0, jt.enableTDO}, 64'd1);
        stream = 10'b11_0100_1101;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, stream[i]);
            check("byp_echo", {63'b0, jt.TDO}, {63'b0, stream[i]});
        end
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        check("byp_en_off", {63'b0, jt.enableTDO}, 64'd0);

        // INTEST via Shift_IR with a 4-cycle Pause_IR
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        shift_bits(64'd3, 3, d);
        check("ir_capture", d, 64'b001);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("ir_hold_pause", {61'b0, ir_value}, 64'd7);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        check("ir_hold_update", {61'b0, ir_value}, 64'd7);
        tick(1'b0, 1'b0);
        check("ir_intest", {61'b0, ir_value}, 64'd3);

        // INTEST: drive an adder core through the BSR and capture its result
        pat1 = {5'b01001, 9'b0_1010_1010};
        scan_dr({50'b0, pat1}, 14, 3, d);
        check("bsr_capture0", d, {50'b0, 5'h00, 9'h0F0});
        check("intest_core_in", {55'b0, core_in}, {55'b0, pat1[8:0]});
        check("intest_pin_out", {59'b0, pin_out}, {59'b0, pat1[13:9]});
        core_out_v = core_model(pat1[8:0]);
        pat2 = {5'b00000, 9'b1_0011_0101};
        scan_dr({50'b0, pat2}, 14, 0, d);
        check("intest_capture", d, {50'b0, 5'b10100, 9'h0F0});
        check("intest_core_in2", {55'b0, core_in}, {55'b0, pat2[8:0]});

        // IDCODE readout, or 1-bit bypass when the register is not built
        scan_ir(3'd5, 0);
        check("ir_idcode", {61'b0, ir_value}, 64'd5);
        din = 64'h0000_0001_5A3C_96E7;
        scan_dr(din, 33, 0, d);
`ifdef JTAG_IDCODE_EN
        check("idcode_stream", {31'b0, d[32:0]}, {31'b0, din[0], IDV});
`else
        check("idcode_bypass", {31'b0, d[32:0]}, {31'b0, din[31:0], 1'b0});
`endif

        // EXTEST latch load, then the mux vector table
        scan_ir(3'd0, 0);
        cur_op = 3'd0;
        scan_dr({50'b0, 5'b10110, 9'h0A5}, 14, 0, d);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].op != cur_op) begin
                scan_ir(vecs[i].op, 0);
                cur_op = vecs[i].op;
            end
            pin_v      = vecs[i].pin;
            core_out_v = vecs[i].cout;
            #1;
            check("vec_core_in", {55'b0, core_in}, {55'b0, vecs[i].exp_ci});
            check("vec_pin_out", {59'b0, pin_out}, {59'b0, vecs[i].exp_po});
        end

        // five TMS=1 cycles from the middle of a Shift_DR
        pin_v = 9'h1AB; core_out_v = 5'h09;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        check("tms_rst_ir", {61'b0, ir_value}, 64'd7);
        check("tms_rst_pin_out", {59'b0, pin_out}, {59'b0, core_out_v});
        check("tms_rst_core_in", {55'b0, core_in}, {55'b0, pin_v});
        check("tms_rst_en", {63'b0, jt.enableTDO}, 64'd0);
        check_bypass_from_tlr("tms_tlr");

        // TRST during Pause_IR
        scan_ir(3'd0, 0);
        scan_dr({50'b0, 5'b01101, 9'h000}, 14, 0, d);
        check("pre_trst_pin_out", {59'b0, pin_out}, 64'b01101);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        TRST = 1'b0;
        check("trst_ir", {61'b0, ir_value}, 64'd7);
        check("trst_pin_out", {59'b0, pin_out}, {59'b0, core_out_v});
        check("trst_tdo", {63'b0, jt.TDO}, 64'd0);
        check("trst_en", {63'b0, jt.enableTDO}, 64'd0);
        check_bypass_from_tlr("trst_tlr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
